// File: rtl/rom_boot_loader.sv
// Boot sequencer: copies the program ROM image into main memory as little-endian
// 32-bit words, then releases the CPU from reset (or flags an error on overrun).
module rom_boot_loader #(
    parameter logic [31:0] MEM_BASE   = 32'h0,
    parameter int unsigned MAX_BYTES  = 4096,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_write_req,
    input  logic        mem_write_ack,
    output logic [31:0] bytes_loaded,
    output logic        busy,
    output logic        boot_done,
    output logic        boot_error,
    output logic        cpu_reset_n
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [31:0] MAX_BYTES_W = 32'(MAX_BYTES);

    state_t      state_r, state_s;
    logic [31:0] rom_address_r, rom_address_s;
    logic [31:0] mem_address_r, mem_address_s;
    logic [31:0] mem_data_r, mem_data_s;
    logic        req_r, req_s;
    logic [31:0] bytes_r, bytes_s;
    logic [1:0]  lane_r, lane_s;
    logic        flush_r, flush_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        error_r, error_s;
    logic        cpu_rst_n_r, cpu_rst_n_s;

    // Next-state and next-register computation; status flags decode the next state so they stay registered.
    always_comb begin
        state_s       = state_r;
        rom_address_s = rom_address_r;
        mem_address_s = mem_address_r;
        mem_data_s    = mem_data_r;
        req_s         = req_r;
        bytes_s       = bytes_r;
        lane_s        = lane_r;
        flush_s       = flush_r;

        case (state_r)
            ST_IDLE: begin
                if (AUTO_START || start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // The marker byte itself is never loaded; a partial word is flushed zero-padded.
                if (rom_done) begin
                    if (lane_r != 2'd0) begin
                        state_s = ST_WRITE;
                        flush_s = 1'b1;
                        req_s   = 1'b1;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else if (bytes_r == MAX_BYTES_W) begin
                    state_s = ST_ERROR;
                end else begin
                    mem_data_s[{lane_r, 3'b000} +: 8] = rom_byte;
                    rom_address_s = rom_address_r + 32'd1;
                    bytes_s       = bytes_r + 32'd1;
                    lane_s        = lane_r + 2'd1;
                    if (lane_r == 2'd3) begin
                        state_s = ST_WRITE;
                        req_s   = 1'b1;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_write_ack) begin
                    req_s         = 1'b0;
                    mem_address_s = mem_address_r + 32'd4;
                    mem_data_s    = 32'd0;
                    lane_s        = 2'd0;
                    flush_s       = 1'b0;
                    if (flush_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            ST_ERROR: begin
                state_s = ST_ERROR;
            end
            default: begin
                state_s = ST_ERROR;
                req_s   = 1'b0;
            end
        endcase

        busy_s      = (state_s == ST_FETCH) || (state_s == ST_WRITE);
        done_s      = (state_s == ST_DONE);
        error_s     = (state_s == ST_ERROR);
        cpu_rst_n_s = (state_s == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rom_address_r <= 32'd0;
            mem_address_r <= MEM_BASE;
            mem_data_r    <= 32'd0;
            req_r         <= 1'b0;
            bytes_r       <= 32'd0;
            lane_r        <= 2'd0;
            flush_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            cpu_rst_n_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            rom_address_r <= rom_address_s;
            mem_address_r <= mem_address_s;
            mem_data_r    <= mem_data_s;
            req_r         <= req_s;
            bytes_r       <= bytes_s;
            lane_r        <= lane_s;
            flush_r       <= flush_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            error_r       <= error_s;
            cpu_rst_n_r   <= cpu_rst_n_s;
        end
    end

    assign rom_address   = rom_address_r;
    assign mem_address   = mem_address_r;
    assign mem_data      = mem_data_r;
    assign mem_write_req = req_r;
    assign bytes_loaded  = bytes_r;
    assign busy          = busy_r;
    assign boot_done     = done_r;
    assign boot_error    = error_r;
    assign cpu_reset_n   = cpu_rst_n_r;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Scoreboard bench for rom_boot_loader: expected writes are queued by the stimulus,
// monitors pop and compare on every accepted memory write.
module tb_rom_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default parameters.
    logic        rst_n_a = 1'b0, start_a = 1'b0, ack_a = 1'b0;
    logic [31:0] rom_address_a, mem_address_a, mem_data_a, bytes_a;
    logic [7:0]  rom_byte_a;
    logic        rom_done_a, req_a, busy_a, done_a, err_a, cpu_a;

    // Aux instance: manual start, small overrun guard, non-zero base.
    logic        rst_n_b = 1'b0, start_b = 1'b0, ack_b = 1'b0;
    logic [31:0] rom_address_b, mem_address_b, mem_data_b, bytes_b;
    logic [7:0]  rom_byte_b;
    logic        rom_done_b, req_b, busy_b, done_b, err_b, cpu_b;

    rom_boot_loader dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a),
        .rom_address(rom_address_a), .rom_byte(rom_byte_a), .rom_done(rom_done_a),
        .mem_address(mem_address_a), .mem_data(mem_data_a),
        .mem_write_req(req_a), .mem_write_ack(ack_a),
        .bytes_loaded(bytes_a), .busy(busy_a), .boot_done(done_a),
        .boot_error(err_a), .cpu_reset_n(cpu_a)
    );

    rom_boot_loader #(.MEM_BASE(32'h0000_1000), .MAX_BYTES(16), .AUTO_START(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b),
        .rom_address(rom_address_b), .rom_byte(rom_byte_b), .rom_done(rom_done_b),
        .mem_address(mem_address_b), .mem_data(mem_data_b),
        .mem_write_req(req_b), .mem_write_ack(ack_b),
        .bytes_loaded(bytes_b), .busy(busy_b), .boot_done(done_b),
        .boot_error(err_b), .cpu_reset_n(cpu_b)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // ROM images: kind 0 = generated 196-byte image, kind 1 = bytes 11,12,...
    int          img_kind = 0;
    logic [31:0] img_len  = 32'd196;

    function automatic logic [7:0] img_byte(input int kind, input logic [31:0] a);
        logic [31:0] t;
        if (kind == 1) begin
            t = a + 32'd11;
            return t[7:0];
        end
        if (a < 32'd16) begin
            case (a[3:0])
                4'd0, 4'd4: return 8'h01;
                4'd8:       return 8'h05;
                4'd12:      return 8'h0A;
                default:    return 8'h00;
            endcase
        end
        if (a >= 32'd192) return 8'h00;
        t = a * 32'd7 + 32'd3;
        return t[7:0];
    endfunction

    function automatic logic [31:0] model_word(input int kind, input logic [31:0] len, input int w);
        logic [31:0] d;
        logic [31:0] idx;
        d = 32'd0;
        for (int k = 0; k < 4; k++) begin
            idx = 32'(4 * w + k);
            if (idx < len) d[8*k +: 8] = img_byte(kind, idx);
        end
        return d;
    endfunction

    assign rom_byte_a = img_byte(img_kind, rom_address_a);
    assign rom_done_a = (rom_address_a == img_len);
    assign rom_byte_b = rom_address_b[7:0] + 8'h20;
    assign rom_done_b = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];
    int  wcount_a = 0, wcount_b = 0;
    int  delay_word = -1, delay_len = 0;

    // Monitor A: acks (optionally late), checks hold stability and pops the scoreboard.
    logic        in_req = 1'b0;
    int          cnt = 0, hold = 0;
    logic [31:0] h_addr, h_data, h_rom;
    wr_t         e_a;
    always @(negedge clk) begin
        if (req_a) begin
            if (!in_req) begin
                in_req = 1'b1;
                cnt    = (wcount_a == delay_word) ? delay_len : 0;
                hold   = 0;
                h_addr = mem_address_a;
                h_data = mem_data_a;
                h_rom  = rom_address_a;
            end else begin
                chk("hold_addr", mem_address_a, h_addr);
                chk("hold_data", mem_data_a, h_data);
                chk("hold_rom_address", rom_address_a, h_rom);
            end
            hold++;
            if (cnt == 0) begin
                ack_a = 1'b1;
                if (q_a.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write_a: got addr 0x%08h data 0x%08h, none required", mem_address_a, mem_data_a);
                end else begin
                    e_a = q_a.pop_front();
                    chk("write_addr_a", mem_address_a, e_a.addr);
                    chk("write_data_a", mem_data_a, e_a.data);
                end
                if (wcount_a == delay_word) chk("req_hold_cycles", 32'(hold), 32'(delay_len + 1));
                wcount_a++;
                in_req = 1'b0;
            end else begin
                ack_a = 1'b0;
                cnt--;
            end
        end else begin
            ack_a  = 1'b0;
            in_req = 1'b0;
        end
    end

    // Monitor B: immediate ack, pops the scoreboard.
    wr_t e_b;
    always @(negedge clk) begin
        if (req_b) begin
            ack_b = 1'b1;
            if (q_b.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write_b: got addr 0x%08h data 0x%08h, none required", mem_address_b, mem_data_b);
            end else begin
                e_b = q_b.pop_front();
                chk("write_addr_b", mem_address_b, e_b.addr);
                chk("write_data_b", mem_data_b, e_b.data);
            end
            wcount_b++;
        end else begin
            ack_b = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end_a(input int budget);
        int n = 0;
        while (!(done_a || err_a) && n < budget) begin
            tick();
            n++;
        end
        chk1("end_reached_a", done_a | err_a, 1'b1);
    endtask

    task automatic push_generated(input int nwords);
        logic [31:0] hand [4];
        logic [31:0] d;
        hand = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0005, 32'h0000_000A};
        for (int w = 0; w < nwords; w++) begin
            if (w < 4) d = hand[w];
            else if (w == 48) d = 32'h0000_0000;
            else d = model_word(0, 32'd196, w);
            q_a.push_back('{addr: 32'(4 * w), data: d});
        end
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_rom_address"}, rom_address_a, 32'd0);
        chk({tag, "_mem_data"}, mem_data_a, 32'd0);
        chk({tag, "_mem_address"}, mem_address_a, 32'd0);
        chk({tag, "_bytes"}, bytes_a, 32'd0);
        chk1({tag, "_req"}, req_a, 1'b0);
        chk1({tag, "_busy"}, busy_a, 1'b0);
        chk1({tag, "_done"}, done_a, 1'b0);
        chk1({tag, "_error"}, err_a, 1'b0);
        chk1({tag, "_cpu_reset_n"}, cpu_a, 1'b0);
    endtask

    task automatic check_full_load(input string tag);
        chk1({tag, "_done"}, done_a, 1'b1);
        chk1({tag, "_cpu_reset_n"}, cpu_a, 1'b1);
        chk1({tag, "_error"}, err_a, 1'b0);
        chk1({tag, "_busy"}, busy_a, 1'b0);
        chk({tag, "_bytes"}, bytes_a, 32'd196);
        chk({tag, "_writes"}, 32'(wcount_a), 32'd49);
        chk({tag, "_pending"}, 32'(q_a.size()), 32'd0);
        chk({tag, "_mem_address"}, mem_address_a, 32'h0000_00C4);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check_reset_a("reset");
        chk1("reset_b_cpu_reset_n", cpu_b, 1'b0);

        // Full generated image, immediate ack.
        push_generated(49);
        wcount_a = 0;
        rst_n_a  = 1'b1;
        repeat (10) tick();
        chk1("loading_cpu_reset_n", cpu_a, 1'b0);
        chk1("loading_busy", busy_a, 1'b1);
        wait_end_a(2000);
        check_full_load("full");
        tick();
        chk1("done_sticky", done_a, 1'b1);

        // Reset while word 10 is pending, then reload with a late ack on word 2.
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        q_a.delete();
        wcount_a   = 0;
        delay_word = 10;
        delay_len  = 100000;
        for (int w = 0; w < 10; w++) q_a.push_back('{addr: 32'(4 * w), data: model_word(0, 32'd196, w)});
        n = 0;
        while (!(wcount_a == 10 && req_a) && n < 1000) begin
            tick();
            n++;
        end
        chk1("reached_word10_req", req_a, 1'b1);
        repeat (2) tick();
        rst_n_a = 1'b0;
        tick();
        check_reset_a("midload_reset");
        chk("midload_pending", 32'(q_a.size()), 32'd0);
        wcount_a   = 0;
        delay_word = 2;
        delay_len  = 5;
        push_generated(49);
        rst_n_a = 1'b1;
        wait_end_a(2000);
        check_full_load("reload");

        // Short image: marker at address 6, second word flushed zero-padded.
        rst_n_a = 1'b0;
        tick();
        img_kind   = 1;
        img_len    = 32'd6;
        delay_word = -1;
        wcount_a   = 0;
        q_a.push_back('{addr: 32'h0, data: 32'h0E0D_0C0B});
        q_a.push_back('{addr: 32'h4, data: 32'h0000_100F});
        rst_n_a = 1'b1;
        wait_end_a(200);
        chk1("short_done", done_a, 1'b1);
        chk1("short_cpu_reset_n", cpu_a, 1'b1);
        chk("short_bytes", bytes_a, 32'd6);
        chk("short_writes", 32'(wcount_a), 32'd2);
        chk("short_pending", 32'(q_a.size()), 32'd0);

        // Empty image: one FETCH cycle, then DONE with no writes.
        rst_n_a = 1'b0;
        tick();
        img_len  = 32'd0;
        wcount_a = 0;
        rst_n_a  = 1'b1;
        tick();
        chk1("empty_fetch_busy", busy_a, 1'b1);
        chk1("empty_fetch_done", done_a, 1'b0);
        tick();
        chk1("empty_done", done_a, 1'b1);
        chk1("empty_cpu_reset_n", cpu_a, 1'b1);
        chk("empty_bytes", bytes_a, 32'd0);
        chk("empty_writes", 32'(wcount_a), 32'd0);

        // Manual start and overrun guard on the aux instance.
        rst_n_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("idle_busy_b", busy_b, 1'b0);
            chk("idle_rom_address_b", rom_address_b, 32'd0);
        end
        q_b.push_back('{addr: 32'h1000, data: 32'h2322_2120});
        q_b.push_back('{addr: 32'h1004, data: 32'h2726_2524});
        q_b.push_back('{addr: 32'h1008, data: 32'h2B2A_2928});
        q_b.push_back('{addr: 32'h100C, data: 32'h2F2E_2D2C});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!(done_b || err_b) && n < 200) begin
            tick();
            n++;
        end
        chk1("overrun_error", err_b, 1'b1);
        chk1("overrun_done", done_b, 1'b0);
        chk1("overrun_cpu_reset_n", cpu_b, 1'b0);
        chk1("overrun_busy", busy_b, 1'b0);
        chk("overrun_bytes", bytes_b, 32'd16);
        chk("overrun_writes", 32'(wcount_b), 32'd4);
        chk("overrun_pending", 32'(q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
